tlight_lamp_monitor: RTL and testbench

Safety monitor and lamp driver placed directly downstream of the traffic-light controller. It consumes the controller's `ns`/`we` aspect outputs (`tlight_control_t` from `tlight_package`) and drives one-hot lamp outputs. It checks every aspect change for conflicts, illegal sequences and short greens. On any violation it latches a fault and forces both directions to flashing yellow until the fault is cleared.

---
 rtl/tlight_package.sv | 10 +
 rtl/tlight_lamp_monitor_if.sv | 23 ++
 rtl/tlight_lamp_monitor.sv | 193 +++++++++++++++++++
 tb/tb_tlight_lamp_monitor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tlight_package.sv
// Shared aspect encoding used by the traffic-light controller and its downstream monitor.
package tlight_package;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } tlight_control_t;

endpackage

// File: rtl/tlight_lamp_monitor_if.sv
// Aspect inputs, fault-clear request and lamp/fault outputs of tlight_lamp_monitor.
interface tlight_lamp_monitor_if;
    import tlight_package::*;

    tlight_control_t ns;
    tlight_control_t we;
    logic            fault_clear;
    logic [2:0]      ns_lamp;
    logic [2:0]      we_lamp;
    logic            fault;
    logic [1:0]      fault_code;

    modport master (
        output ns, we, fault_clear,
        input  ns_lamp, we_lamp, fault, fault_code
    );

    modport slave (
        input  ns, we, fault_clear,
        output ns_lamp, we_lamp, fault, fault_code
    );

endinterface

// File: rtl/tlight_lamp_monitor.sv
// Safety monitor / lamp driver behind the traffic-light controller; latches faults and flashes yellow.
// Optional short-green check built when TLIGHT_LAMP_MONITOR_DWELL_CHECK_EN is defined.
module tlight_lamp_monitor
    import tlight_package::*;
#(
    parameter int MIN_GREEN  = 10,
    parameter int BLINK_HALF = 1
) (
    input logic           clock,
    input logic           reset,
    tlight_lamp_monitor_if.slave bus
);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    localparam logic [3:0] BLINK_LAST = 4'(BLINK_HALF - 1);

    if (MIN_GREEN < 1 || MIN_GREEN > 31) begin : g_bad_min_green
        $error("MIN_GREEN out of range 1..31");
    end
    if (BLINK_HALF < 1 || BLINK_HALF > 15) begin : g_bad_blink_half
        $error("BLINK_HALF out of range 1..15");
    end

    function automatic logic [2:0] decode(input tlight_control_t c);
        case (c)
            RED:     decode = 3'b100;
            YELLOW:  decode = 3'b010;
            GREEN:   decode = 3'b001;
            default: decode = 3'b000;
        endcase
    endfunction

    function automatic logic is_valid(input tlight_control_t c);
        is_valid = (c == RED) || (c == YELLOW) || (c == GREEN);
    endfunction

    function automatic logic is_legal(input tlight_control_t p, input tlight_control_t c);
        is_legal = (p == c) ||
                   (p == RED    && c == YELLOW) ||
                   (p == YELLOW && c == GREEN)  ||
                   (p == GREEN  && c == YELLOW) ||
                   (p == YELLOW && c == RED);
    endfunction

    state_t          state, state_next;
    tlight_control_t prev_ns, prev_we, prev_ns_next, prev_we_next;
    logic [3:0]      blink_cnt, blink_cnt_next;
    logic            blink_phase, blink_phase_next;
    logic [2:0]      ns_lamp_next, we_lamp_next;
    logic            fault_next;
    logic [1:0]      fault_code_next;

    logic       conflict, bad_seq, short_green, exit_ok;
    logic [1:0] code;

    assign conflict = (bus.ns != RED) && (bus.we != RED);
    assign bad_seq  = !is_valid(bus.ns) || !is_valid(bus.we) ||
                      !is_legal(prev_ns, bus.ns) || !is_legal(prev_we, bus.we);
    assign exit_ok  = bus.fault_clear && (bus.ns == RED) && (bus.we == RED);

`ifdef TLIGHT_LAMP_MONITOR_DWELL_CHECK_EN
    localparam logic [4:0] MIN_G = 5'(MIN_GREEN);

    logic [4:0] green_cnt_ns, green_cnt_we;

    function automatic logic [4:0] green_step(input tlight_control_t c, input logic [4:0] cnt);
        if (c != GREEN)
            green_step = 5'd0;
        else if (cnt == 5'd31)
            green_step = cnt;
        else
            green_step = cnt + 5'd1;
    endfunction

    assign short_green = (prev_ns == GREEN && bus.ns != GREEN && green_cnt_ns < MIN_G) ||
                         (prev_we == GREEN && bus.we != GREEN && green_cnt_we < MIN_G);

    // Counters only advance on clean RUN cycles; leaving FAULT restarts them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            green_cnt_ns <= 5'd0;
            green_cnt_we <= 5'd0;
        end else if (state == RUN && code == 2'd0) begin
            green_cnt_ns <= green_step(bus.ns, green_cnt_ns);
            green_cnt_we <= green_step(bus.we, green_cnt_we);
        end else if (state == FAULT && exit_ok) begin
            green_cnt_ns <= 5'd0;
            green_cnt_we <= 5'd0;
        end
    end
`else
    assign short_green = 1'b0;
`endif

    always_comb begin
        code = 2'd0;
        if (conflict)
            code = 2'd1;
        else if (bad_seq)
            code = 2'd2;
        else if (short_green)
            code = 2'd3;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (code != 2'd0) state_next = FAULT;
            FAULT:   if (exit_ok)      state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        ns_lamp_next     = bus.ns_lamp;
        we_lamp_next     = bus.we_lamp;
        fault_next       = bus.fault;
        fault_code_next  = bus.fault_code;
        prev_ns_next     = prev_ns;
        prev_we_next     = prev_we;
        blink_cnt_next   = blink_cnt;
        blink_phase_next = blink_phase;
        case (state)
            RUN: begin
                if (code != 2'd0) begin
                    ns_lamp_next     = 3'b000;
                    we_lamp_next     = 3'b000;
                    fault_next       = 1'b1;
                    fault_code_next  = code;
                    blink_cnt_next   = 4'd0;
                    blink_phase_next = 1'b0;
                end else begin
                    ns_lamp_next = decode(bus.ns);
                    we_lamp_next = decode(bus.we);
                    prev_ns_next = bus.ns;
                    prev_we_next = bus.we;
                end
            end
            FAULT: begin
                if (exit_ok) begin
                    ns_lamp_next    = 3'b100;
                    we_lamp_next    = 3'b100;
                    fault_next      = 1'b0;
                    fault_code_next = 2'd0;
                    prev_ns_next    = RED;
                    prev_we_next    = RED;
                end else begin
                    // Lamps follow the phase being written, so the first flash lands BLINK_HALF edges in.
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_next   = 4'd0;
                        blink_phase_next = !blink_phase;
                    end else begin
                        blink_cnt_next = blink_cnt + 4'd1;
                    end
                    ns_lamp_next = blink_phase_next ? 3'b010 : 3'b000;
                    we_lamp_next = blink_phase_next ? 3'b010 : 3'b000;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.ns_lamp    <= 3'b100;
            bus.we_lamp    <= 3'b100;
            bus.fault      <= 1'b0;
            bus.fault_code <= 2'd0;
            prev_ns        <= RED;
            prev_we        <= RED;
            blink_cnt      <= 4'd0;
            blink_phase    <= 1'b0;
        end else begin
            bus.ns_lamp    <= ns_lamp_next;
            bus.we_lamp    <= we_lamp_next;
            bus.fault      <= fault_next;
            bus.fault_code <= fault_code_next;
            prev_ns        <= prev_ns_next;
            prev_we        <= prev_we_next;
            blink_cnt      <= blink_cnt_next;
            blink_phase    <= blink_phase_next;
        end
    end

endmodule

// File: tb/tb_tlight_lamp_monitor.sv
// Directed bench for tlight_lamp_monitor: normal cycling, each fault code, flash timing, clear and reset.
module tb_tlight_lamp_monitor;
    import tlight_package::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    always #5 clock = ~clock;

    tlight_lamp_monitor_if bus();
    tlight_lamp_monitor_if bus_slow();

    assign bus_slow.ns          = bus.ns;
    assign bus_slow.we          = bus.we;
    assign bus_slow.fault_clear = bus.fault_clear;

    tlight_lamp_monitor #(.MIN_GREEN(10), .BLINK_HALF(1)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    tlight_lamp_monitor #(.MIN_GREEN(10), .BLINK_HALF(3)) dut_slow (
        .clock(clock), .reset(reset), .bus(bus_slow)
    );

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    function automatic logic [2:0] lamp_of(input tlight_control_t c);
        case (c)
            RED:     lamp_of = 3'b100;
            YELLOW:  lamp_of = 3'b010;
            GREEN:   lamp_of = 3'b001;
            default: lamp_of = 3'b000;
        endcase
    endfunction

    task automatic step(input tlight_control_t n, input tlight_control_t w, input logic clr);
        bus.ns          = n;
        bus.we          = w;
        bus.fault_clear = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_run(input string tag, input tlight_control_t n, input tlight_control_t w);
        check({tag, " ns_lamp"}, bus.ns_lamp, lamp_of(n));
        check({tag, " we_lamp"}, bus.we_lamp, lamp_of(w));
        check({tag, " fault"},   3'(bus.fault), 3'd0);
    endtask

    task automatic expect_fault(input string tag, input logic [2:0] code, input logic [2:0] lamp);
        check({tag, " fault"},   3'(bus.fault), 3'd1);
        check({tag, " code"},    3'(bus.fault_code), code);
        check({tag, " ns_lamp"}, bus.ns_lamp, lamp);
        check({tag, " we_lamp"}, bus.we_lamp, lamp);
    endtask

    task automatic seg(input string tag, input tlight_control_t n, input tlight_control_t w, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(n, w, 1'b0);
            expect_run(tag, n, w);
        end
    endtask

    task automatic clear_to_red(input string tag);
        step(RED, RED, 1'b1);
        expect_run(tag, RED, RED);
        check({tag, " code"}, 3'(bus.fault_code), 3'd0);
    endtask

    task automatic normal_cycle();
        seg("norm rr",  RED,    RED,    2);
        seg("norm wy",  RED,    YELLOW, 3);
        seg("norm wg",  RED,    GREEN,  15);
        seg("norm wy2", RED,    YELLOW, 3);
        seg("norm rr2", RED,    RED,    1);
        seg("norm ny",  YELLOW, RED,    3);
        seg("norm ng",  GREEN,  RED,    15);
        seg("norm ny2", YELLOW, RED,    3);
        seg("norm rr3", RED,    RED,    1);
    endtask

    initial begin
        reset           = 1'b1;
        bus.ns          = RED;
        bus.we          = RED;
        bus.fault_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset ns_lamp", bus.ns_lamp, 3'b100);
        check("reset we_lamp", bus.we_lamp, 3'b100);
        check("reset fault",   3'(bus.fault), 3'd0);
        check("reset code",    3'(bus.fault_code), 3'd0);
        reset = 1'b0;

        normal_cycle();
        normal_cycle();

        // Conflict, then flash: fast instance every cycle, slow instance every third.
        step(RED, YELLOW, 1'b0);
        expect_run("pre conflict", RED, YELLOW);
        step(GREEN, YELLOW, 1'b0);
        expect_fault("conflict", 3'd1, 3'b000);
        check("slow conflict fault", 3'(bus_slow.fault), 3'd1);
        check("slow conflict lamp",  bus_slow.ns_lamp, 3'b000);
        for (int i = 1; i <= 4; i++) begin
            step(GREEN, YELLOW, 1'b0);
            expect_fault($sformatf("flash %0d", i), 3'd1, (i % 2 == 1) ? 3'b010 : 3'b000);
            check($sformatf("slow flash %0d", i), bus_slow.we_lamp, (i >= 3) ? 3'b010 : 3'b000);
        end

        // Clear refused while an input is not RED.
        step(YELLOW, RED, 1'b1);
        expect_fault("clear refused", 3'd1, 3'b010);
        check("slow clear refused", bus_slow.ns_lamp, 3'b010);
        clear_to_red("clear ok");
        check("slow clear fault", 3'(bus_slow.fault), 3'd0);
        check("slow clear lamp",  bus_slow.we_lamp, 3'b100);

        step(RED, GREEN, 1'b0);
        expect_fault("illegal r->g", 3'd2, 3'b000);
        clear_to_red("clear illegal");

        step(YELLOW, GREEN, 1'b0);
        expect_fault("conflict+illegal", 3'd1, 3'b000);
        clear_to_red("clear conflict+illegal");

        step(RED, tlight_control_t'(2'd3), 1'b0);
        expect_fault("invalid aspect", 3'd2, 3'b000);
        clear_to_red("clear invalid");

        // Short green: 9 cycles of GREEN then YELLOW.
        seg("dwell9 wy", RED, YELLOW, 1);
        seg("dwell9 wg", RED, GREEN, 9);
        step(RED, YELLOW, 1'b0);
`ifdef TLIGHT_LAMP_MONITOR_DWELL_CHECK_EN
        expect_fault("short green", 3'd3, 3'b000);
        clear_to_red("clear short green");
`else
        expect_run("short green off", RED, YELLOW);
        clear_to_red("clear in run");
`endif
        seg("dwell10 wy",  RED, YELLOW, 1);
        seg("dwell10 wg",  RED, GREEN,  10);
        seg("dwell10 wy2", RED, YELLOW, 1);
        seg("dwell10 rr",  RED, RED,    1);

        // Asynchronous reset during FAULT.
        step(GREEN, GREEN, 1'b0);
        expect_fault("pre reset fault", 3'd1, 3'b000);
        #2 reset = 1'b1;
        #1;
        check("reset in fault ns_lamp", bus.ns_lamp, 3'b100);
        check("reset in fault we_lamp", bus.we_lamp, 3'b100);
        check("reset in fault fault",   3'(bus.fault), 3'd0);
        check("reset in fault code",    3'(bus.fault_code), 3'd0);
        bus.ns = RED;
        bus.we = RED;
        #2 reset = 1'b0;

        // Asynchronous reset part-way through a green run.
        seg("green run wy", RED, YELLOW, 1);
        seg("green run wg", RED, GREEN,  5);
        #2 reset = 1'b1;
        #1;
        check("reset in green we_lamp", bus.we_lamp, 3'b100);
        check("reset in green fault",   3'(bus.fault), 3'd0);
        bus.ns = RED;
        bus.we = RED;
        #2 reset = 1'b0;
        seg("after reset rr",  RED, RED,    1);
        seg("after reset wy",  RED, YELLOW, 1);
        seg("after reset wg",  RED, GREEN,  10);
        seg("after reset wy2", RED, YELLOW, 1);
        check("after reset code", 3'(bus.fault_code), 3'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
